// File: rtl/two_d_conv_s_p.sv
// ----------------------------------------------------------------------------
// two_d_conv_s_p
//   Streaming 2-D convolution of an NxN signed fixed-point matrix with an MxM
//   kernel, with run-time stride and zero padding.  Both matrices arrive
//   serially during LOAD; the O*O results are then produced one at a time in
//   row-major order, each taking M*M multiply-accumulate cycles plus one emit
//   cycle.
//
//   Optional build macro: SATURATION_EN
//     defined   : results outside the Width-bit signed range clamp to max/min
//     undefined : results keep the low Width bits (two's-complement wrap)
//
// Parameters
//   Width  data width of a, b, out (Q(Width-FRAC).FRAC)
//   FRAC   fractional bits; accumulated products are shifted right by FRAC
//   MAX_N  largest supported input dimension
//   MAX_M  largest supported kernel dimension
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   a      input-matrix element stream (row-major, LOAD only)
//   b      kernel element stream (row-major, first M*M LOAD edges only)
//   n      input dimension          m  kernel dimension
//   s      stride                   p  zero padding per side
//   o      output dimension, (n+2p-m)/s+1, supplied by the user
//   out    registered result, held between emits
//   done   one-cycle strobe marking a new value on out
// ----------------------------------------------------------------------------
module two_d_conv_s_p #(
   parameter int unsigned Width = 16,
   parameter int unsigned FRAC  = 8,
   parameter int unsigned MAX_N = 8,
   parameter int unsigned MAX_M = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] a,
   input  logic [Width-1:0] b,
   input  logic [5:0]       n,
   input  logic [5:0]       m,
   input  logic [5:0]       s,
   input  logic [5:0]       p,
   input  logic [5:0]       o,
   output logic [Width-1:0] out,
   output logic             done
);

   localparam int unsigned InDepth  = MAX_N * MAX_N;
   localparam int unsigned KerDepth = MAX_M * MAX_M;
   localparam int unsigned InAw     = (InDepth > 1) ? $clog2(InDepth) : 1;
   localparam int unsigned KerAw    = (KerDepth > 1) ? $clog2(KerDepth) : 1;
   localparam int unsigned AccW     = 2 * Width + 8;
   localparam logic [6:0]  MaxN7    = 7'(MAX_N);
   localparam logic [6:0]  MaxM7    = 7'(MAX_M);

   typedef enum logic [1:0] {StLoad, StCompute, StEmit, StFinish} state_e;

   state_e                 state_q, state_d;
   logic [11:0]            k_q, k_d;
   logic [5:0]             r_q, r_d, c_q, c_d;
   logic [5:0]             i_q, i_d, j_q, j_d;
   logic signed [AccW-1:0] acc_q, acc_d;
   logic [Width-1:0]       out_q, out_d;
   logic                   done_q, done_d;
   logic                   we_in, we_ker;

   logic [Width-1:0]       in_mem  [InDepth];
   logic [Width-1:0]       ker_mem [KerDepth];

   // Configuration derived terms
   logic [11:0] nn, mm;
   logic        cfg_bad;

   assign nn = n * n;
   assign mm = m * m;

   always_comb begin
      cfg_bad = (n == 6'd0) || (m == 6'd0) || (s == 6'd0) ||
                ({1'b0, n} > MaxN7) || ({1'b0, m} > MaxM7) ||
                ({2'b0, m} > ({2'b0, n} + {1'b0, p, 1'b0}));
   end

   // Source coordinates of the current MAC; signed so that the padded border
   // produces negative values instead of aliasing into the buffer.
   logic [11:0]             rs, cs;
   logic signed [15:0]      row, col;
   logic [15:0]             row_u, col_u, in_lin;
   logic [11:0]             ker_lin;
   logic                    pix_valid;
   logic [Width-1:0]        pixel, kval;
   logic signed [2*Width-1:0] prod;
   logic signed [AccW-1:0]  prod_ext;
   logic signed [AccW-1:0]  shifted;
   logic [Width-1:0]        emit_val;

   always_comb begin
      rs        = r_q * s;
      cs        = c_q * s;
      row       = $signed({4'b0, rs}) + $signed({10'b0, i_q}) - $signed({10'b0, p});
      col       = $signed({4'b0, cs}) + $signed({10'b0, j_q}) - $signed({10'b0, p});
      pix_valid = (row >= 16'sd0) && (row < $signed({10'b0, n})) &&
                  (col >= 16'sd0) && (col < $signed({10'b0, n}));
      row_u     = row;
      col_u     = col;
      in_lin    = row_u * {10'b0, n} + col_u;
      ker_lin   = i_q * m + {6'b0, j_q};
      pixel     = pix_valid ? in_mem[in_lin[InAw-1:0]] : '0;
      kval      = ker_mem[ker_lin[KerAw-1:0]];
      prod      = $signed(pixel) * $signed(kval);
      prod_ext  = {{(AccW - 2 * Width){prod[2*Width-1]}}, prod};
   end

   // Arithmetic shift rounds toward -inf.
   assign shifted = acc_q >>> FRAC;

`ifdef SATURATION_EN
   localparam logic signed [AccW-1:0] SatMax =
      {{(AccW - Width + 1){1'b0}}, {(Width - 1){1'b1}}};
   localparam logic signed [AccW-1:0] SatMin =
      {{(AccW - Width + 1){1'b1}}, {(Width - 1){1'b0}}};

   always_comb begin
      if (shifted > SatMax) begin
         emit_val = SatMax[Width-1:0];
      end else if (shifted < SatMin) begin
         emit_val = SatMin[Width-1:0];
      end else begin
         emit_val = shifted[Width-1:0];
      end
   end
`else
   assign emit_val = shifted[Width-1:0];
`endif

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      r_d     = r_q;
      c_d     = c_q;
      i_d     = i_q;
      j_d     = j_q;
      acc_d   = acc_q;
      out_d   = out_q;
      done_d  = 1'b0;
      we_in   = 1'b0;
      we_ker  = 1'b0;

      unique case (state_q)
         StLoad: begin
            // The config is only judged on the very first edge after reset.
            if ((k_q == 12'd0) && cfg_bad) begin
               state_d = StFinish;
            end else begin
               we_in  = 1'b1;
               we_ker = (k_q < mm);
               if (k_q == nn - 12'd1) begin
                  state_d = StCompute;
                  k_d     = '0;
                  r_d     = '0;
                  c_d     = '0;
                  i_d     = '0;
                  j_d     = '0;
                  acc_d   = '0;
               end else begin
                  k_d = k_q + 12'd1;
               end
            end
         end

         StCompute: begin
            acc_d = acc_q + prod_ext;
            if (j_q == m - 6'd1) begin
               j_d = '0;
               if (i_q == m - 6'd1) begin
                  i_d     = '0;
                  state_d = StEmit;
               end else begin
                  i_d = i_q + 6'd1;
               end
            end else begin
               j_d = j_q + 6'd1;
            end
         end

         StEmit: begin
            out_d  = emit_val;
            done_d = 1'b1;
            acc_d  = '0;
            if (c_q == o - 6'd1) begin
               c_d = '0;
               if (r_q == o - 6'd1) begin
                  state_d = StFinish;
               end else begin
                  r_d     = r_q + 6'd1;
                  state_d = StCompute;
               end
            end else begin
               c_d     = c_q + 6'd1;
               state_d = StCompute;
            end
         end

         StFinish: begin
            state_d = StFinish;
         end

         default: begin
            state_d = StLoad;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoad;
         k_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         r_q     <= r_d;
         c_q     <= c_d;
         i_q     <= i_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   // Buffers carry no reset; every location read is written during LOAD.
   always_ff @(posedge clk) begin
      if (we_in) begin
         in_mem[k_q[InAw-1:0]] <= a;
      end
      if (we_ker) begin
         ker_mem[k_q[KerAw-1:0]] <= b;
      end
   end

   assign out  = out_q;
   assign done = done_q;

   // High address bits are unused once the buffer index has been range-checked.
   logic unused_bits;
`ifdef SATURATION_EN
   assign unused_bits = ^{in_lin[15:InAw], ker_lin[11:KerAw]};
`else
   assign unused_bits = ^{in_lin[15:InAw], ker_lin[11:KerAw], shifted[AccW-1:Width]};
`endif

endmodule

// File: tb/tb_two_d_conv_s_p.sv
// ----------------------------------------------------------------------------
// tb_two_d_conv_s_p
//   Bench for two_d_conv_s_p.  Two instances share one stimulus stream: one
//   with FRAC=0 and one with FRAC=8.  Expected results come from a direct
//   arithmetic evaluation of the convolution sum over the loaded matrices.
// ----------------------------------------------------------------------------
module tb_two_d_conv_s_p;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [5:0]  n = '0, m = '0, s = '0, p = '0, o = '0;
   logic [15:0] out0, out8;
   logic        done0, done8;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] av [64];
   logic [15:0] bv [64];
   logic [15:0] got0 [256];
   logic [15:0] got8 [256];
   int          t1b [9] = '{-1, -2, 3, 4, -5, 6, -7, -8, 9};

   always #5 clk = ~clk;

   two_d_conv_s_p #(.Width(16), .FRAC(0), .MAX_N(8), .MAX_M(4)) dut0 (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .n    (n),
      .m    (m),
      .s    (s),
      .p    (p),
      .o    (o),
      .out  (out0),
      .done (done0)
   );

   two_d_conv_s_p #(.Width(16), .FRAC(8), .MAX_N(8), .MAX_M(4)) dut8 (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .n    (n),
      .m    (m),
      .s    (s),
      .p    (p),
      .o    (o),
      .out  (out8),
      .done (done8)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   // Convolution sum for output (r,c) computed straight from the definition.
   function automatic logic [15:0] model(input int cn, cm, cs, cp, r, c, frac);
      longint acc, px, kv, sh;
      int     row, col;
      acc = 0;
      for (int i = 0; i < cm; i++) begin
         for (int j = 0; j < cm; j++) begin
            row = r * cs + i - cp;
            col = c * cs + j - cp;
            px  = 0;
            if (row >= 0 && row < cn && col >= 0 && col < cn) px = $signed(av[row * cn + col]);
            kv  = $signed(bv[i * cm + j]);
            acc = acc + px * kv;
         end
      end
      sh = acc >>> frac;
`ifdef SATURATION_EN
      if (sh > 32767) sh = 32767;
      else if (sh < -32768) sh = -32768;
`endif
      return sh[15:0];
   endfunction

   task automatic start_case(input int cn, cm, cs, cp, co);
      rst_n = 1'b0;
      n = 6'(cn); m = 6'(cm); s = 6'(cs); p = 6'(cp); o = 6'(co);
      a = '0; b = '0;
      #1;
   endtask

   // stop_after < 0 runs the whole case including the post-finish hold check.
   task automatic run_case(input string tag, input int cn, cm, cs, cp, co,
                           input int stop_after);
      int          lat, nout;
      bit          seen, quiet;
      logic [15:0] e0, e8;
      e0 = '0;
      start_case(cn, cm, cs, cp, co);
      chk({tag, "/rst_out"}, out0, 16'h0000);
      chk({tag, "/rst_done"}, {15'b0, done0}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < cn * cn; k++) begin
         a = av[k];
         b = bv[k];
         @(negedge clk);
      end
      a = 16'h5a5a;
      b = 16'ha5a5;
      nout = co * co;
      if (stop_after >= 0 && stop_after < nout) nout = stop_after;
      for (int idx = 0; idx < nout; idx++) begin
         lat  = 0;
         seen = 1'b0;
         while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = done0;
         end
         chk({tag, "/latency"}, 16'(lat), 16'(cm * cm + 1));
         if (!seen) return;
         e0 = model(cn, cm, cs, cp, idx / co, idx % co, 0);
         e8 = model(cn, cm, cs, cp, idx / co, idx % co, 8);
         got0[idx] = out0;
         got8[idx] = out8;
         chk({tag, "/out_frac0"}, out0, e0);
         chk({tag, "/out_frac8"}, out8, e8);
         chk({tag, "/done_frac8"}, {15'b0, done8}, 16'h0001);
      end
      if (stop_after < 0) begin
         quiet = 1'b1;
         for (int q = 0; q < 3 * (cm * cm + 1) + 4; q++) begin
            @(negedge clk);
            if (done0) quiet = 1'b0;
         end
         chk({tag, "/no_done_after_finish"}, {15'b0, quiet}, 16'h0001);
         chk({tag, "/out_held"}, out0, e0);
      end
   endtask

   task automatic bad_case(input string tag, input int cn, cm, cs, cp);
      bit quiet;
      start_case(cn, cm, cs, cp, 1);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int q = 0; q < 40; q++) begin
         a = 16'(q + 1);
         b = 16'(q + 1);
         @(negedge clk);
         if (done0 || done8) quiet = 1'b0;
      end
      chk({tag, "/no_done"}, {15'b0, quiet}, 16'h0001);
      chk({tag, "/out_zero"}, out0, 16'h0000);
   endtask

   task automatic load_test1();
      for (int k = 0; k < 64; k++) begin
         av[k] = 16'(k + 1);
         bv[k] = (k < 9) ? 16'(t1b[k]) : 16'h7777;
      end
   endtask

   initial begin
      int cn, cm, cs, cp, co;

      // 1: padded 4x4 with 3x3 signed kernel
      load_test1();
      run_case("t1", 4, 3, 1, 1, 4, -1);
      chk("t1/first", got0[0], 16'd21);
      chk("t1/second", got0[1], 16'hfff8);

      // 2: single output then finish
      for (int k = 0; k < 64; k++) begin
         av[k] = 16'(k + 1);
         bv[k] = 16'd1;
      end
      run_case("t2", 3, 3, 1, 0, 1, -1);
      chk("t2/sum", got0[0], 16'd45);

      // 3: stride 2
      run_case("t3", 4, 2, 2, 0, 2, -1);
      chk("t3/o0", got0[0], 16'd14);
      chk("t3/o1", got0[1], 16'd22);
      chk("t3/o2", got0[2], 16'd46);
      chk("t3/o3", got0[3], 16'd54);

      // 4: overflow of the output range
      av[0] = 16'h7fff;
      bv[0] = 16'h7fff;
      run_case("t4", 1, 1, 1, 0, 1, -1);
`ifdef SATURATION_EN
      chk("t4/overflow", got0[0], 16'h7fff);
`else
      chk("t4/overflow", got0[0], 16'h0001);
`endif

      // 5: fixed-point product on the FRAC=8 instance
      av[0] = 16'h0180;
      bv[0] = 16'h0200;
      run_case("t5", 1, 1, 1, 0, 1, -1);
      chk("t5/q8_product", got8[0], 16'h0300);

      // 6: reset in the middle of COMPUTE, then a clean rerun
      load_test1();
      run_case("t6a", 4, 3, 1, 1, 4, 2);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6/async_out0", out0, 16'h0000);
      chk("t6/async_done0", {15'b0, done0}, 16'h0000);
      chk("t6/async_out8", out8, 16'h0000);
      run_case("t6b", 4, 3, 1, 1, 4, -1);
      chk("t6b/first", got0[0], 16'd21);
      chk("t6b/second", got0[1], 16'hfff8);

      // Rejected configurations
      bad_case("bad_n0", 0, 1, 1, 0);
      bad_case("bad_m0", 4, 0, 1, 0);
      bad_case("bad_s0", 4, 2, 0, 0);
      bad_case("bad_nbig", 9, 2, 1, 0);
      bad_case("bad_mbig", 8, 5, 1, 0);
      bad_case("bad_mwide", 2, 3, 1, 0);

      // Random configurations and data
      for (int t = 0; t < 8; t++) begin
         cn = $urandom_range(1, 8);
         cm = $urandom_range(1, (cn < 4) ? cn : 4);
         cp = $urandom_range(0, 2);
         cs = $urandom_range(1, 3);
         co = (cn + 2 * cp - cm) / cs + 1;
         for (int k = 0; k < 64; k++) begin
            av[k] = 16'($urandom);
            bv[k] = 16'($urandom);
         end
         run_case($sformatf("rnd%0d", t), cn, cm, cs, cp, co, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
